// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution-stage issue controller:
// opcodes, ALU function encodings, FSM states and the opcode decode table.
package exec_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       uses_src;
    logic       writes;
    logic       is_halt;
    logic [1:0] aluc;
    logic       selc_b;
  } dec_t;

  // Reserved opcodes fall through to the all-zero NOP decode.
  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD:  begin d.uses_src = 1'b1; d.writes = 1'b1; d.aluc = ALU_ADD; end
      OP_SUB:  begin d.uses_src = 1'b1; d.writes = 1'b1; d.aluc = ALU_SUB; end
      OP_AND:  begin d.uses_src = 1'b1; d.writes = 1'b1; d.aluc = ALU_AND; end
      OP_OR:   begin d.uses_src = 1'b1; d.writes = 1'b1; d.aluc = ALU_OR;  end
      OP_LDI:  begin d.writes = 1'b1; d.selc_b = 1'b1; d.aluc = ALU_ADD; end
      OP_HALT: d.is_halt = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one bit per architectural register.
// A set and a clear to the same index in one cycle leaves the bit set.
module reg_scoreboard #(
  parameter int NREG = 16,
  parameter int IDXW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [IDXW-1:0] set_idx,
  input  logic            clr_en,
  input  logic [IDXW-1:0] clr_idx,
  output logic [NREG-1:0] pending,
  output logic            empty
);

  logic [NREG-1:0] pending_next;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_en && (set_idx == IDXW'(gi));
      assign clr_hit = clr_en && (clr_idx == IDXW'(gi));
      assign pending_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pending[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign empty = ~|pending;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: decodes ops, blocks on scoreboard hazards,
// registers execution-stage controls and runs the halt-and-drain FSM.
module issue_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int NREG = 16,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  output logic                    dec_ready,
  input  logic [3:0]              dec_op,
  input  logic [$clog2(NREG)-1:0] dec_rs1,
  input  logic [$clog2(NREG)-1:0] dec_rs2,
  input  logic [$clog2(NREG)-1:0] dec_rd,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  output logic [1:0]              aluc,
  output logic                    selc_b,
  output logic                    we,
  output logic [$clog2(NREG)-1:0] rdestr,
  output logic                    issue_valid,
  output logic                    halted,
  output logic [CNTW-1:0]         stall_cnt
);

  localparam int IDXW = $clog2(NREG);

  state_t          state;
  state_t          state_next;
  dec_t            d;
  logic [NREG-1:0] pending;
  logic            sb_empty;
  logic            hazard;
  logic            accept;
  logic            issue;
  logic            stall_evt;

  assign d = decode(dec_op);

  // Hazards look only at the registered scoreboard; a writeback this cycle
  // unblocks the dependent op on the following cycle.
  assign hazard = (d.uses_src && (pending[dec_rs1] || pending[dec_rs2]))
               || (d.writes && pending[dec_rd]);

  always_comb begin
    state_next = state;
    dec_ready  = 1'b0;
    case (state)
      RUN: begin
        dec_ready = !hazard;
        if (dec_valid && !hazard && d.is_halt) state_next = DRAIN;
      end
      DRAIN: begin
        if (sb_empty) state_next = HALTED;
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  assign accept    = dec_valid && dec_ready;
  assign issue     = accept && d.writes;
  assign stall_evt = (state == RUN) && dec_valid && hazard;

  reg_scoreboard #(.NREG(NREG), .IDXW(IDXW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue),
    .set_idx (dec_rd),
    .clr_en  (wb_we),
    .clr_idx (wb_rd),
    .pending (pending),
    .empty   (sb_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // aluc/selc_b/rdestr keep the last issued values across empty slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluc        <= ALU_ADD;
      selc_b      <= 1'b0;
      we          <= 1'b0;
      rdestr      <= '0;
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= issue;
      we          <= issue;
      if (issue) begin
        aluc   <= d.aluc;
        selc_b <= d.selc_b;
        rdestr <= dec_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: a vector table run through an expected-output queue,
// then hand sequences for drain/halt, async reset and counter saturation.
module tb_issue_ctrl;
  import exec_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [3:0]  dec_op = '0;
  logic [3:0]  dec_rs1 = '0;
  logic [3:0]  dec_rs2 = '0;
  logic [3:0]  dec_rd = '0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [1:0]  aluc;
  logic        selc_b;
  logic        we;
  logic [3:0]  rdestr;
  logic        issue_valid;
  logic        halted;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  issue_ctrl #(.NREG(16), .CNTW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_op      (dec_op),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .aluc        (aluc),
    .selc_b      (selc_b),
    .we          (we),
    .rdestr      (rdestr),
    .issue_valid (issue_valid),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        wbwe;
    logic [3:0]  wbrd;
    logic        ready;
    logic        issue;
    logic [1:0]  aluc;
    logic        sel;
    logic [3:0]  rdd;
    logic [15:0] stall;
  } vec_t;

  typedef struct {
    logic       iv;
    logic       we;
    logic [1:0] aluc;
    logic       sel;
    logic [3:0] rd;
  } exp_t;

  localparam int NV = 22;
  vec_t vecs[NV];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int v, input int op, input int rs1, input int rs2,
                              input int rd, input int ww, input int wr, input int rdy,
                              input int iss, input int al, input int sel, input int rdd,
                              input int st);
    vec_t r;
    r.valid = 1'(v);    r.op = 4'(op);    r.rs1 = 4'(rs1); r.rs2 = 4'(rs2);
    r.rd = 4'(rd);      r.wbwe = 1'(ww);  r.wbrd = 4'(wr); r.ready = 1'(rdy);
    r.issue = 1'(iss);  r.aluc = 2'(al);  r.sel = 1'(sel); r.rdd = 4'(rdd);
    r.stall = 16'(st);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd,
                       input logic ww, input logic [3:0] wr);
    @(negedge clk);
    dec_valid = v; dec_op = op; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    wb_we = ww; wb_rd = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] h_aluc;
    logic       h_sel;
    logic [3:0] h_rd;
    exp_t       e;
    int         k;

    //          v op rs1 rs2 rd ww wr rdy iss al sel rdd stall
    vecs[0]  = mk(1, 1, 1, 2, 3,  0, 0, 1, 1, 0, 0, 3,  0);
    vecs[1]  = mk(1, 2, 3, 0, 4,  0, 0, 0, 0, 0, 0, 0,  1);
    vecs[2]  = mk(1, 2, 3, 0, 4,  0, 0, 0, 0, 0, 0, 0,  2);
    vecs[3]  = mk(1, 2, 3, 0, 4,  0, 0, 0, 0, 0, 0, 0,  3);
    vecs[4]  = mk(1, 2, 3, 0, 4,  1, 3, 0, 0, 0, 0, 0,  4);
    vecs[5]  = mk(1, 2, 3, 0, 4,  0, 0, 1, 1, 1, 0, 4,  4);
    vecs[6]  = mk(1, 5, 0, 0, 5,  0, 0, 1, 1, 0, 1, 5,  4);
    vecs[7]  = mk(1, 5, 0, 0, 6,  0, 0, 1, 1, 0, 1, 6,  4);
    vecs[8]  = mk(1, 5, 0, 0, 7,  1, 7, 1, 1, 0, 1, 7,  4);
    vecs[9]  = mk(1, 4, 1, 7, 8,  0, 0, 0, 0, 0, 0, 0,  5);
    vecs[10] = mk(1, 4, 1, 7, 8,  1, 7, 0, 0, 0, 0, 0,  6);
    vecs[11] = mk(1, 4, 1, 7, 8,  0, 0, 1, 1, 3, 0, 8,  6);
    vecs[12] = mk(1, 0, 4, 5, 6,  0, 0, 1, 0, 0, 0, 0,  6);
    vecs[13] = mk(1, 9, 4, 5, 6,  0, 0, 1, 0, 0, 0, 0,  6);
    vecs[14] = mk(0, 1, 1, 2, 9,  0, 0, 1, 0, 0, 0, 0,  6);
    vecs[15] = mk(1, 3, 0, 2, 5,  1, 4, 0, 0, 0, 0, 0,  7);
    vecs[16] = mk(1, 3, 0, 2, 5,  1, 5, 0, 0, 0, 0, 0,  8);
    vecs[17] = mk(1, 3, 0, 2, 5,  1, 6, 1, 1, 2, 0, 5,  8);
    vecs[18] = mk(1, 0, 0, 0, 0,  1, 8, 1, 0, 0, 0, 0,  8);
    vecs[19] = mk(0, 0, 0, 0, 0,  1, 5, 1, 0, 0, 0, 0,  8);
    vecs[20] = mk(1, 1, 1, 2, 10, 0, 0, 1, 1, 0, 0, 10, 8);
    vecs[21] = mk(1, 2, 11, 12, 13, 0, 0, 1, 1, 1, 0, 13, 8);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst issue_valid", 32'(issue_valid), 0);
    check("rst we", 32'(we), 0);
    check("rst aluc", 32'(aluc), 0);
    check("rst selc_b", 32'(selc_b), 0);
    check("rst rdestr", 32'(rdestr), 0);
    check("rst halted", 32'(halted), 0);
    check("rst stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b1;

    h_aluc = 2'b00; h_sel = 1'b0; h_rd = 4'd0;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].wbwe, vecs[i].wbrd);
      check($sformatf("v%0d dec_ready", i), 32'(dec_ready), 32'(vecs[i].ready));
      if (vecs[i].issue) begin
        h_aluc = vecs[i].aluc; h_sel = vecs[i].sel; h_rd = vecs[i].rdd;
      end
      q.push_back('{iv: vecs[i].issue, we: vecs[i].issue, aluc: h_aluc, sel: h_sel, rd: h_rd});
      tick();
      if (q.size() == 0) begin
        check($sformatf("v%0d queue", i), 32'(q.size()), 1);
      end else begin
        e = q.pop_front();
        check($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(e.iv));
        check($sformatf("v%0d we", i), 32'(we), 32'(e.we));
        check($sformatf("v%0d aluc", i), 32'(aluc), 32'(e.aluc));
        check($sformatf("v%0d selc_b", i), 32'(selc_b), 32'(e.sel));
        check($sformatf("v%0d rdestr", i), 32'(rdestr), 32'(e.rd));
        check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].stall));
      end
    end

    // Halt with r4, r10, r13 pending; drain until the last writeback.
    drive(1, OP_LDI, 0, 0, 4, 0, 0);
    tick();
    check("A ldi issue_valid", 32'(issue_valid), 1);
    check("A ldi selc_b", 32'(selc_b), 1);
    check("A ldi rdestr", 32'(rdestr), 4);
    drive(1, OP_HALT, 0, 0, 0, 0, 0);
    check("A halt ready", 32'(dec_ready), 1);
    tick();
    check("A halt issue_valid", 32'(issue_valid), 0);
    check("A halt we", 32'(we), 0);
    check("A halt rdestr hold", 32'(rdestr), 4);
    drive(1, OP_ADD, 4, 0, 1, 1, 10);
    check("A drain ready hazard", 32'(dec_ready), 0);
    tick();
    check("A drain stall_cnt", 32'(stall_cnt), 8);
    check("A drain halted0", 32'(halted), 0);
    drive(1, OP_NOP, 0, 0, 0, 1, 13);
    check("A drain ready nop", 32'(dec_ready), 0);
    tick();
    drive(1, OP_NOP, 0, 0, 0, 0, 0);
    tick();
    check("A r4 pending halted", 32'(halted), 0);
    drive(1, OP_NOP, 0, 0, 0, 1, 4);
    tick();
    drive(0, OP_NOP, 0, 0, 0, 0, 0);
    k = 0;
    while (!halted && k < 4) begin
      tick();
      k++;
    end
    check("A halted reached", 32'(halted), 1);
    for (int j = 0; j < 3; j++) begin
      drive(1, OP_LDI, 0, 0, 9, 0, 0);
      check($sformatf("A halted%0d ready", j), 32'(dec_ready), 0);
      tick();
      check($sformatf("A halted%0d halted", j), 32'(halted), 1);
      check($sformatf("A halted%0d issue_valid", j), 32'(issue_valid), 0);
    end

    @(negedge clk);
    rst = 1'b0;
    dec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("A after rst halted", 32'(halted), 0);
    @(negedge clk);
    rst = 1'b1;

    // Saturation: r2 pending and never written back.
    drive(1, OP_LDI, 0, 0, 2, 0, 0);
    tick();
    drive(1, OP_ADD, 2, 0, 3, 0, 0);
    repeat (65533) @(posedge clk);
    tick();
    check("C stall_cnt FFFE", 32'(stall_cnt), 32'hFFFE);
    tick();
    check("C stall_cnt FFFF", 32'(stall_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("C stall_cnt sticks", 32'(stall_cnt), 32'hFFFF);

    // Async reset mid-DRAIN (r2, r4 pending).
    drive(1, OP_LDI, 0, 0, 4, 0, 0);
    tick();
    drive(1, OP_HALT, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    dec_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("B rst issue_valid", 32'(issue_valid), 0);
    check("B rst we", 32'(we), 0);
    check("B rst aluc", 32'(aluc), 0);
    check("B rst selc_b", 32'(selc_b), 0);
    check("B rst rdestr", 32'(rdestr), 0);
    check("B rst halted", 32'(halted), 0);
    check("B rst stall_cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, OP_NOP, 0, 0, 0, 1, 4);
    tick();
    drive(1, OP_ADD, 4, 2, 4, 0, 0);
    check("B post-rst ready", 32'(dec_ready), 1);
    tick();
    check("B post-rst issue_valid", 32'(issue_valid), 1);
    check("B post-rst rdestr", 32'(rdestr), 4);
    check("B post-rst halted", 32'(halted), 0);
    check("B post-rst stall_cnt", 32'(stall_cnt), 0);
    drive(0, OP_NOP, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
